vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator; successor to the fixed 640x480@60 generator that drives the demoscene renderers. Produces sync, blanking, pixel coordinates, line/frame strobes and a free-running frame counter from one clock. Adds configurable geometry, sync polarity, a pixel clock-enable, and a lookahead so the coordinate outputs lead sync/blanking. The lookahead lets multi-cycle pixel pipelines land in step with `display_on`.

## Interface
Parameters:
- `H_DISPLAY` 640, `H_FRONT` 16, `H_SYNC` 96, `H_BACK` 48: horizontal timing in pixels; H_TOTAL = sum.
- `V_DISPLAY` 480, `V_FRONT` 10, `V_SYNC` 2, `V_BACK` 33: vertical timing in lines; V_TOTAL = sum.
- `HSYNC_POL` 0, `VSYNC_POL` 0: sync active level. 0 means active-low.
- `LOOKAHEAD` 0: number of pixel steps (0..7) by which `hpos`/`vpos` lead `hsync`/`vsync`/`display_on`.
- `COORD_W` 10: coordinate width. Requires H_TOTAL and V_TOTAL ≤ 2^COORD_W.
- `FRAME_W` 16: frame counter width.

Ports:
- `clk` in 1: pixel-domain clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: pixel advance enable. Tie high for a 1:1 pixel clock.
- `hsync` out 1: horizontal sync, polarity per HSYNC_POL.
- `vsync` out 1: vertical sync, polarity per VSYNC_POL.
- `display_on` out 1: visible-area flag, delayed by LOOKAHEAD.
- `hpos` out COORD_W: current horizontal counter, 0..H_TOTAL-1.
- `vpos` out COORD_W: current vertical counter, 0..V_TOTAL-1.
- `line_start` out 1: one-clk pulse when hpos enters 0.
- `frame_start` out 1: one-clk pulse when (hpos,vpos) enters (0,0) via wrap.
- `frame_cnt` out FRAME_W: completed-frame count, modulo 2^FRAME_W.

## Operation
- **Counters.** On each clk with `en`=1:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps to 0 after V_TOTAL-1.
  - With `en`=0, all state holds.
- **Raw signals.** Decoded from the *next* counter value and registered, so they are aligned with hpos/vpos without glitches:
  - raw_hs active iff H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC.
  - raw_vs active iff V_DISPLAY+V_FRONT ≤ v < V_DISPLAY+V_FRONT+V_SYNC.
  - raw_de = (h < H_DISPLAY) && (v < V_DISPLAY).
- **Lookahead delay.** raw_hs/raw_vs/raw_de pass through a LOOKAHEAD-deep shift register that advances only on `en`=1. The outputs are the last stage; with LOOKAHEAD=0 there is no extra delay.
- **Polarity.** Applied at the outputs: `hsync` = raw_hs ? HSYNC_POL : ~HSYNC_POL. `vsync` follows the same rule with VSYNC_POL.
- **Strobes and frame counter.**
  - `line_start` is registered high for exactly one clk on the advance that sets hpos to 0, including the frame wrap.
  - `frame_start` is registered high on the advance that wraps (H_TOTAL-1,V_TOTAL-1) to (0,0).
  - `frame_cnt` increments on that same clk edge and wraps 2^FRAME_W-1 to 0.
  - Both strobes are 0 whenever `en` was 0 on the preceding edge.
- **Reset** (`rst_n`=0 at a clk edge, overrides `en`):
  - hpos=0, vpos=0, frame_cnt=0.
  - `line_start`=0, `frame_start`=0, `display_on`=0.
  - Sync outputs at their inactive level; all delay stages flushed to inactive/0.
  - Reset in mid-frame behaves identically. No strobe is emitted on reset exit.
- **Illegal parameters.** Any zero-width timing field, or totals exceeding 2^COORD_W: the block must fail elaboration via a generate-time check.

## Timing
- **Latency.** hpos/vpos lead `display_on`, `hsync` and `vsync` by exactly LOOKAHEAD `en`-qualified steps. With LOOKAHEAD=0 all of them change on the same edge.
- **Periods.**
  - Line period: H_TOTAL enabled clocks.
  - Frame period: H_TOTAL×V_TOTAL enabled clocks (420000 at defaults with `en`=1).
- **First frame after reset release.**
  - First advance: hpos 0→1, with no `line_start`.
  - First `frame_start` occurs after a full frame.
- **Pipeline fill.** For the first LOOKAHEAD steps after reset, the delayed outputs show the reset (inactive) values.

## Test plan
- **Reset values.** Hold `rst_n`=0 for 3 clks mid-frame at (hpos=300, vpos=200) → next edge gives hpos=0, vpos=0, frame_cnt=0, hsync=vsync=1, display_on=0, strobes 0.
- **Default timing, LOOKAHEAD=0, `en`=1.**
  - hsync low exactly while hpos ∈ [656,751].
  - vsync low exactly while vpos ∈ [490,491].
  - display_on high for exactly 640×480 clks per frame.
  - line_start every 800 clks; frame_start every 420000 clks.
- **Frame counter wrap.** FRAME_W=4 with shrunk geometry (all fields 2/2/1/1) → frame_cnt counts 0..15, returns to 0 on the 16th frame_start, and a pulse is seen each frame.
- **Lookahead.** LOOKAHEAD=3 → display_on falls exactly 3 clks after hpos becomes 640, and hsync asserts exactly 3 clks after hpos becomes 656.
- **Clock enable.** `en` toggles 1,0,1,0 → counters advance every other clk. Line period becomes 1600 clks, strobes stay one clk wide, and no strobe appears on an `en`=0 cycle.
- **Polarity.** HSYNC_POL=1, VSYNC_POL=1 → hsync high only for hpos ∈ [656,751] and idles low after reset; vsync behaves likewise.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
// Sync, blanking, coordinates, line/frame strobes, frame counter.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOOKAHEAD = 0,
  parameter int COORD_W   = 10,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT
                         + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT
                         + V_SYNC + V_BACK;
  localparam int HS_BEG  = H_DISPLAY + H_FRONT;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_DISPLAY + V_FRONT;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam bit BAD_H = (H_DISPLAY < 1) || (H_FRONT < 1)
                      || (H_SYNC < 1) || (H_BACK < 1);
  localparam bit BAD_V = (V_DISPLAY < 1) || (V_FRONT < 1)
                      || (V_SYNC < 1) || (V_BACK < 1);
  localparam bit BAD_W = (COORD_W < 1) || (COORD_W > 30)
                      || (H_TOTAL > (1 << COORD_W))
                      || (V_TOTAL > (1 << COORD_W))
                      || (FRAME_W < 1);
  localparam bit BAD_L = (LOOKAHEAD < 0) || (LOOKAHEAD > 7);

  generate
    if (BAD_H || BAD_V || BAD_W || BAD_L) begin : g_bad
      $error("vga_timing_gen: illegal parameters");
    end
  endgenerate

  logic               h_wrap;
  logic               v_wrap;
  logic [COORD_W-1:0] h_nxt;
  logic [COORD_W-1:0] v_nxt;
  logic               hs_n;
  logic               vs_n;
  logic               de_n;
  logic               hs_r;
  logic               vs_r;
  logic               de_r;
  logic               hs_o;
  logic               vs_o;
  logic               de_o;

  // Next counter value and the raw signals decoded from it.
  always_comb begin
    h_wrap = (hpos == COORD_W'(H_TOTAL - 1));
    v_wrap = (vpos == COORD_W'(V_TOTAL - 1));
    h_nxt  = h_wrap ? '0 : hpos + COORD_W'(1);
    v_nxt  = vpos;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vpos + COORD_W'(1);
    end
    hs_n = (int'(h_nxt) >= HS_BEG)
        && (int'(h_nxt) < HS_END);
    vs_n = (int'(v_nxt) >= VS_BEG)
        && (int'(v_nxt) < VS_END);
    de_n = (int'(h_nxt) < H_DISPLAY)
        && (int'(v_nxt) < V_DISPLAY);
  end

  // Counters, strobes, frame count and raw sync registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      frame_cnt   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_r        <= 1'b0;
      vs_r        <= 1'b0;
      de_r        <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        hpos        <= h_nxt;
        vpos        <= v_nxt;
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
        if (h_wrap && v_wrap) begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
        hs_r <= hs_n;
        vs_r <= vs_n;
        de_r <= de_n;
      end
    end
  end

  generate
    if (LOOKAHEAD > 0) begin : g_dly
      logic [LOOKAHEAD-1:0] hs_d;
      logic [LOOKAHEAD-1:0] vs_d;
      logic [LOOKAHEAD-1:0] de_d;

      // Delay line so coordinates lead sync/blanking.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hs_d <= '0;
          vs_d <= '0;
          de_d <= '0;
        end else if (en) begin
          hs_d <= (hs_d << 1) | LOOKAHEAD'(hs_r);
          vs_d <= (vs_d << 1) | LOOKAHEAD'(vs_r);
          de_d <= (de_d << 1) | LOOKAHEAD'(de_r);
        end
      end

      assign hs_o = hs_d[LOOKAHEAD-1];
      assign vs_o = vs_d[LOOKAHEAD-1];
      assign de_o = de_d[LOOKAHEAD-1];
    end else begin : g_nodly
      assign hs_o = hs_r;
      assign vs_o = vs_r;
      assign de_o = de_r;
    end
  endgenerate

  assign hsync      = hs_o ? HSYNC_POL : ~HSYNC_POL;
  assign vsync      = vs_o ? VSYNC_POL : ~VSYNC_POL;
  assign display_on = de_o;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen.
// Five instances cover default, lookahead, polarity and wrap cases.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic en;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_h, d_v;
  logic [15:0] d_fc;
  logic       m_hs, m_vs, m_de, m_ls, m_fs;
  logic [9:0] m_h, m_v;
  logic [15:0] m_fc;
  logic       l_hs, l_vs, l_de, l_ls, l_fs;
  logic [9:0] l_h, l_v;
  logic [15:0] l_fc;
  logic       p_hs, p_vs, p_de, p_ls, p_fs;
  logic [9:0] p_h, p_v;
  logic [15:0] p_fc;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_h, s_v;
  logic [3:0] s_fc;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
    .hpos(d_h), .vpos(d_v),
    .line_start(d_ls), .frame_start(d_fs),
    .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) u_mid (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(m_hs), .vsync(m_vs), .display_on(m_de),
    .hpos(m_h), .vpos(m_v),
    .line_start(m_ls), .frame_start(m_fs),
    .frame_cnt(m_fc)
  );

  vga_timing_gen #(
    .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .LOOKAHEAD(3)
  ) u_la (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(l_hs), .vsync(l_vs), .display_on(l_de),
    .hpos(l_h), .vpos(l_v),
    .line_start(l_ls), .frame_start(l_fs),
    .frame_cnt(l_fc)
  );

  vga_timing_gen #(
    .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(p_hs), .vsync(p_vs), .display_on(p_de),
    .hpos(p_h), .vpos(p_v),
    .line_start(p_ls), .frame_start(p_fs),
    .frame_cnt(p_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(2), .H_FRONT(2), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(2), .V_SYNC(1), .V_BACK(1),
    .FRAME_W(4)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
    .hpos(s_h), .vpos(s_v),
    .line_start(s_ls), .frame_start(s_fs),
    .frame_cnt(s_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  int hs_bad = 0, ls_n = 0, ls_bad = 0, ls_last = 0;
  int d_fs_n = 0, vs_bad = 0, de_cnt = 0;
  int m_fs_n = 0, m_fs_first = 0, m_fs_last = 0;
  int m_fs_bad = 0;
  int l_h640 = 0, l_h656 = 0, la_de_n = 0, la_hs_n = 0;
  int la_bad = 0, pol_bad = 0, s_fs_n = 0, s_bad = 0;
  int hold_bad = 0, en_ls_bad = 0, en_ls_n = 0;
  int t0 = 0, t1 = 0;
  logic l_de_prev, l_hs_prev, in_w, ls_prev, e;
  logic [9:0] prev_h;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) step();
    chk("rst_hpos", d_h, 0);
    chk("rst_vpos", d_v, 0);
    chk("rst_fcnt", d_fc, 0);
    chk("rst_hsync", d_hs, 1);
    chk("rst_vsync", d_vs, 1);
    chk("rst_de", d_de, 0);
    chk("rst_ls", d_ls, 0);
    chk("rst_fs", d_fs, 0);
    chk("rst_pol_hs", p_hs, 0);
    chk("rst_pol_vs", p_vs, 0);
    chk("rst_la_de", l_de, 0);
    chk("rst_la_hs", l_hs, 1);

    rst_n = 1'b1;
    step();
    chk("first_hpos", d_h, 1);
    chk("first_ls", d_ls, 0);
    chk("first_fs", m_fs, 0);
    l_de_prev = l_de;
    l_hs_prev = l_hs;

    for (int k = 2; k <= 20000; k++) begin
      step();
      in_w = (d_h >= 656) && (d_h <= 751);
      if (d_hs !== !in_w) hs_bad++;
      if (d_ls) begin
        ls_n++;
        if (d_h != 0) ls_bad++;
        if (ls_last != 0 && k - ls_last != 800)
          ls_bad++;
        ls_last = k;
      end
      if (d_fs) d_fs_n++;

      if (m_vs !== !(m_v == 6 || m_v == 7)) vs_bad++;
      if (k >= 8000 && k < 16000 && m_de) de_cnt++;
      if (m_fs) begin
        if (m_fs_n == 0) m_fs_first = k;
        else if (k - m_fs_last != 8000) m_fs_bad++;
        m_fs_last = k;
        m_fs_n++;
      end

      if (l_h == 640) l_h640 = k;
      if (l_h == 656) l_h656 = k;
      if (l_de_prev && !l_de) begin
        la_de_n++;
        if (k - l_h640 != 3) la_bad++;
      end
      if (l_hs_prev && !l_hs) begin
        la_hs_n++;
        if (k - l_h656 != 3) la_bad++;
      end
      l_de_prev = l_de;
      l_hs_prev = l_hs;

      if (p_hs !== ((p_h >= 656) && (p_h <= 751)))
        pol_bad++;
      if (p_vs !== (p_v == 6 || p_v == 7))
        pol_bad++;

      if (s_fs) begin
        s_fs_n++;
        if (s_fc !== 4'(s_fs_n)) s_bad++;
      end
      if (k == 540) chk("s_fc_15", s_fc, 15);
      if (k == 576) begin
        chk("s_fc_wrap", s_fc, 0);
        chk("s_fs_wrap", s_fs, 1);
      end
    end

    chk("hs_window", hs_bad, 0);
    chk("ls_count", ls_n, 25);
    chk("ls_period", ls_bad, 0);
    chk("def_no_fs", d_fs_n, 0);
    chk("vs_window", vs_bad, 0);
    chk("de_per_frame", de_cnt, 2560);
    chk("fs_first", m_fs_first, 8000);
    chk("fs_count", m_fs_n, 2);
    chk("fs_period", m_fs_bad, 0);
    chk("m_fcnt", m_fc, 2);
    chk("la_de_falls", la_de_n, 12);
    chk("la_hs_falls", la_hs_n, 25);
    chk("la_delay", la_bad, 0);
    chk("pol_sync", pol_bad, 0);
    chk("s_fc_track", s_bad, 0);
    chk("s_fs_count", s_fs_n, 555);

    repeat (1100) step();
    chk("pre_rst_h", m_h, 300);
    chk("pre_rst_v", m_v, 6);
    chk("pre_rst_vs", m_vs, 0);
    rst_n = 1'b0;
    repeat (3) step();
    chk("mid_rst_h", m_h, 0);
    chk("mid_rst_v", m_v, 0);
    chk("mid_rst_fc", m_fc, 0);
    chk("mid_rst_hs", m_hs, 1);
    chk("mid_rst_vs", m_vs, 1);
    chk("mid_rst_de", m_de, 0);
    chk("mid_rst_ls", m_ls, 0);
    chk("mid_rst_fs", m_fs, 0);
    rst_n = 1'b1;
    step();
    chk("exit_h", m_h, 1);
    chk("exit_ls", m_ls, 0);
    chk("exit_fs", m_fs, 0);

    ls_prev = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      en = (i % 2 == 0);
      e = en;
      prev_h = d_h;
      step();
      if (!e && d_h != prev_h) hold_bad++;
      if (e && d_h == prev_h) hold_bad++;
      if (d_ls) begin
        if (!e) en_ls_bad++;
        if (ls_prev) en_ls_bad++;
        if (en_ls_n == 0) t0 = i;
        if (en_ls_n == 1) t1 = i;
        en_ls_n++;
      end
      ls_prev = d_ls;
    end
    en = 1'b1;
    chk("en_hold", hold_bad, 0);
    chk("en_ls_strobe", en_ls_bad, 0);
    chk("en_ls_count", en_ls_n, 2);
    chk("en_ls_first", t0, 1596);
    chk("en_ls_period", t1 - t0, 1600);
    chk("en_end_h", d_h, 401);
    chk("en_end_v", d_v, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
